microwave_control: RTL and testbench
====================================

# microwave_control

Top-level sequencer for the microwave timer datapath. Drives load, clear and countdown enable for the cascaded mod-10 digit counters, gates the magnetron, and reacts to the door interlock and the counters' all-zero flag. Sits between the keypad/door front end and the timer chain; the cascade's least-significant digit receives `timer_enable`.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per countdown tick (1 Hz at 50 MHz); minimum 2.
- `ALARM_TICKS`, 3: ticks the alarm stays on in DONE (only with `MICROWAVE_ALARM_EN`).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `clearn`  in  1  reset; synchronous, active-low.
- `start`  in  1  start/resume request, level, one-cycle-sampled.
- `stop`  in  1  pause/cancel request.
- `clear_key`  in  1  zero the timer digits.
- `load_key`  in  1  keypad value valid on counter `input_number` buses; load it.
- `door_closed`  in  1  interlock; 1 = closed.
- `timer_done`  in  1  AND of all digit `zero` flags.
- `timer_loadn`  out  1  to all digits' `loadn`.
- `timer_clearn`  out  1  to all digits' `clearn`.
- `timer_enable`  out  1  to least-significant digit `enable`; one-cycle pulse per tick.
- `mag_on`  out  1  magnetron/lamp/turntable drive.
- `alarm`  out  1  end-of-cook beeper.
- `state`  out  3  current state code, for display/debug.

## Operation
- States: IDLE, COOKING, PAUSED, DONE. Reset -> IDLE.
- All outputs registered. Reset values: `timer_loadn`=1, `timer_clearn`=1, `timer_enable`=0, `mag_on`=0, `alarm`=0, `state`=IDLE; prescaler=0.
- Input priority in each cycle: `stop` > `clear_key` > `load_key` > `start`.
- IDLE: `clear_key` -> `timer_clearn` low one cycle. `load_key` -> `timer_loadn` low one cycle. `start` & `door_closed` & !`timer_done` -> COOKING, prescaler cleared. `start` with door open or `timer_done`=1 ignored.
- COOKING: `mag_on`=1. Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 wraps and `timer_enable` pulses one cycle, suppressed if `timer_done`=1 (prevents 0->9 wrap). `stop` or !`door_closed` -> PAUSED. `timer_done`=1 -> DONE. `load_key`/`clear_key` ignored.
- PAUSED: `mag_on`=0, prescaler held. `start` & `door_closed` -> COOKING, prescaler resumes from held value. `stop` -> IDLE (digits kept). `clear_key` -> IDLE with one-cycle `timer_clearn` low.
- DONE: `mag_on`=0. Exit to IDLE per Configuration.
- Invariant: `timer_loadn`=0 and `timer_clearn`=0 only while `timer_enable`=0; never both low in one cycle.

## Timing
- Input sampled at edge N -> state and registered outputs change after edge N (visible cycle N+1).
- Entering COOKING: `mag_on` high from cycle N+1; first `timer_enable` pulse TICK_DIV cycles after entry, then every TICK_DIV cycles.
- Digit reaching all-zero after a pulse: `timer_done` seen next cycle -> DONE one cycle later; no further pulses.
- Door opening: `mag_on` low one cycle after `door_closed` sampled 0.
- `clearn` low mid-operation: IDLE and reset values on next edge regardless of other inputs.

## Configuration
- `MICROWAVE_ALARM_EN` defined: DONE holds `alarm`=1 for ALARM_TICKS ticks (prescaler reused), then IDLE; any of `start`/`stop`/`clear_key` ends it early -> IDLE next cycle.
- Undefined: `alarm` tied 0, ALARM_TICKS unused; DONE lasts exactly one cycle then IDLE.

## Structure
- Shared package `microwave_pkg`: state encodings (IDLE=0, COOKING=1, PAUSED=2, DONE=3), state width constant.
- Sub-module `tick_gen`: prescaler with `run`, `clr` inputs and `tick` output, parameter TICK_DIV; FSM instantiates one.

## Test plan
- Reset, TICK_DIV=4: all outputs at reset values; `start` with `door_closed`=0 -> stays IDLE, `mag_on`=0.
- `load_key` in IDLE -> `timer_loadn` low exactly 1 cycle, `timer_enable`=0 that cycle; `clear_key` -> `timer_clearn` low 1 cycle.
- Digits loaded 02, `start` -> `mag_on`=1 next cycle, pulses at +4 and +8 cycles, DONE after `timer_done`, exactly 2 pulses total.
- Door opened after first pulse -> PAUSED, `mag_on`=0; close + `start` -> remaining pulse arrives after held prescaler completes.
- `start` and `stop` same cycle in PAUSED -> IDLE; `clearn` low during COOKING -> IDLE, all reset values.
- With `MICROWAVE_ALARM_EN`, ALARM_TICKS=3: `alarm` high 12 cycles in DONE then IDLE; without: DONE one cycle, `alarm`=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared state encodings for the microwave sequencer.
package microwave_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    COOKING = 3'd1,
    PAUSED  = 3'd2,
    DONE    = 3'd3
  } state_t;
endpackage

// File: rtl/microwave_control_tick_gen.sv
// Countdown prescaler: tick is high during the last cycle of each TICK_DIV-cycle period while running.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic clearn,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  // clr has priority so a fresh period can start on the same edge the sequencer changes state
  always_ff @(posedge clock) begin
    if (!clearn)   count <= '0;
    else if (clr)  count <= '0;
    else if (run)  count <= (count == LAST) ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/microwave_control.sv
// Microwave cook sequencer driving the cascaded digit counters and magnetron.
// Optional end-of-cook beeper enabled by defining MICROWAVE_ALARM_EN.
module microwave_control
  import microwave_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 3
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_key,
  input  logic       load_key,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       timer_loadn,
  output logic       timer_clearn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       alarm,
  output logic [2:0] state
);
  state_t cur, nxt;
  logic   tick, pclr, prun;
  logic   loadn_nxt, clearn_nxt;
  logic   alarm_last;

  // The prescaler keeps its count across PAUSED and restarts on entry to COOKING from IDLE or to DONE
  assign prun = (cur == COOKING) || (cur == DONE);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .clearn (clearn),
    .run    (prun),
    .clr    (pclr),
    .tick   (tick)
  );

`ifdef MICROWAVE_ALARM_EN
  localparam int ACW = $clog2(ALARM_TICKS + 1);
  logic [ACW-1:0] acount;

  always_ff @(posedge clock) begin
    if (!clearn)           acount <= '0;
    else if (cur != DONE)  acount <= '0;
    else if (tick)         acount <= acount + 1'b1;
  end

  assign alarm_last = tick && (acount == ACW'(ALARM_TICKS - 1));
`else
  assign alarm_last = 1'b1;
`endif

  always_comb begin
    nxt        = cur;
    loadn_nxt  = 1'b1;
    clearn_nxt = 1'b1;
    pclr       = 1'b0;
    case (cur)
      IDLE: begin
        if (stop)           nxt = IDLE;
        else if (clear_key) clearn_nxt = 1'b0;
        else if (load_key)  loadn_nxt = 1'b0;
        else if (start && door_closed && !timer_done) begin
          nxt  = COOKING;
          pclr = 1'b1;
        end
      end
      COOKING: begin
        if (stop || !door_closed) nxt = PAUSED;
        else if (timer_done) begin
          nxt  = DONE;
          pclr = 1'b1;
        end
      end
      PAUSED: begin
        if (stop)           nxt = IDLE;
        else if (clear_key) begin
          nxt        = IDLE;
          clearn_nxt = 1'b0;
        end
        else if (start && door_closed) nxt = COOKING;
      end
      DONE: begin
        if (start || stop || clear_key || alarm_last) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Registered outputs: everything below is visible the cycle after the inputs are sampled
  always_ff @(posedge clock) begin
    if (!clearn) begin
      cur          <= IDLE;
      timer_loadn  <= 1'b1;
      timer_clearn <= 1'b1;
      timer_enable <= 1'b0;
      mag_on       <= 1'b0;
    end else begin
      cur          <= nxt;
      timer_loadn  <= loadn_nxt;
      timer_clearn <= clearn_nxt;
      timer_enable <= (cur == COOKING) && tick && !timer_done;
      mag_on       <= (nxt == COOKING);
    end
  end

`ifdef MICROWAVE_ALARM_EN
  always_ff @(posedge clock) begin
    if (!clearn) alarm <= 1'b0;
    else         alarm <= (nxt == DONE);
  end
`else
  assign alarm = 1'b0;
`endif

  assign state = cur;
endmodule

// File: tb/tb_microwave_control.sv
// Randomized bench for microwave_control with a cycle-level behavioural model and a two-digit timer stand-in.
module tb_microwave_control;
  localparam int TD = 4;
  localparam int AT = 3;
`ifdef MICROWAVE_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic clearn = 1'b1, start = 1'b0, stop = 1'b0, clear_key = 1'b0, load_key = 1'b0;
  logic door_closed = 1'b1;
  logic timer_done;
  logic timer_loadn, timer_clearn, timer_enable, mag_on, alarm;
  logic [2:0] state;

  microwave_control #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clock(clock), .clearn(clearn), .start(start), .stop(stop),
    .clear_key(clear_key), .load_key(load_key), .door_closed(door_closed),
    .timer_done(timer_done), .timer_loadn(timer_loadn), .timer_clearn(timer_clearn),
    .timer_enable(timer_enable), .mag_on(mag_on), .alarm(alarm), .state(state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Two-digit countdown timer standing in for the digit cascade (wraps 00 -> 99 like real digits)
  int digits = 0;
  int kp_value = 0;
  always @(posedge clock) begin
    if (timer_clearn === 1'b0)      digits <= 0;
    else if (timer_loadn === 1'b0)  digits <= kp_value;
    else if (timer_enable === 1'b1) digits <= (digits == 0) ? 99 : digits - 1;
  end
  assign timer_done = (digits == 0);

  // Behavioural model: mode code, cooking cycles since the last tick, cycles spent in DONE
  localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;
  int  m_mode = M_IDLE;
  int  m_elapsed = 0;
  int  m_done_cyc = 0;
  bit  model_ok = 1'b0;
  int  e_loadn = 1, e_clearn = 1, e_en = 0, e_mag = 0, e_alarm = 0;

  always @(posedge clock) begin
    e_loadn = 1; e_clearn = 1; e_en = 0;
    if (!clearn) begin
      model_ok = 1'b1;
      m_mode = M_IDLE; m_elapsed = 0; m_done_cyc = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (stop) m_mode = M_IDLE;
          else if (clear_key) e_clearn = 0;
          else if (load_key) e_loadn = 0;
          else if (start && door_closed && !timer_done) begin
            m_mode = M_COOK; m_elapsed = 0;
          end
        end
        M_COOK: begin
          m_elapsed++;
          if (m_elapsed == TD) begin
            m_elapsed = 0;
            if (!timer_done) e_en = 1;
          end
          if (stop || !door_closed) m_mode = M_PAUSE;
          else if (timer_done) begin m_mode = M_DONE; m_done_cyc = 0; end
        end
        M_PAUSE: begin
          if (stop) m_mode = M_IDLE;
          else if (clear_key) begin m_mode = M_IDLE; e_clearn = 0; end
          else if (start && door_closed) m_mode = M_COOK;
        end
        default: begin
          m_done_cyc++;
          if (!ALARM_ON) m_mode = M_IDLE;
          else if (start || stop || clear_key || m_done_cyc == AT * TD) m_mode = M_IDLE;
        end
      endcase
    end
    e_mag = (m_mode == M_COOK);
    e_alarm = (ALARM_ON && m_mode == M_DONE);
  end

  always @(negedge clock) begin
    if (model_ok) begin
      check("timer_loadn", timer_loadn, e_loadn);
      check("timer_clearn", timer_clearn, e_clearn);
      check("timer_enable", timer_enable, e_en);
      check("mag_on", mag_on, e_mag);
      check("alarm", alarm, e_alarm);
      check("state", state, m_mode);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input int v);
    kp_value = v; load_key = 1'b1;
    cyc(1);
    load_key = 1'b0;
    cyc(1);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (state == 3'(s)) break;
      cyc(1);
    end
    if (i == budget) check(name, state, s);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_loadn"}, timer_loadn, 1);
    check({tag, "_clearn"}, timer_clearn, 1);
    check({tag, "_enable"}, timer_enable, 0);
    check({tag, "_mag"}, mag_on, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_state"}, state, 0);
  endtask

  initial begin
    int pc, mc, dc, k;
    // Reset and door-open start rejection
    clearn = 1'b0; door_closed = 1'b0;
    cyc(2);
    clearn = 1'b1;
    check_reset_values("reset");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("door_open_state", state, 0);
    check("door_open_mag", mag_on, 0);

    // Load and clear pulses
    door_closed = 1'b1; kp_value = 2; load_key = 1'b1;
    cyc(1);
    load_key = 1'b0;
    check("load_pulse", timer_loadn, 0);
    check("load_no_enable", timer_enable, 0);
    cyc(1);
    check("load_one_cycle", timer_loadn, 1);
    clear_key = 1'b1;
    cyc(1);
    clear_key = 1'b0;
    check("clear_pulse", timer_clearn, 0);
    cyc(1);
    check("clear_one_cycle", timer_clearn, 1);

    // Full cook of 02
    load(2);
    start = 1'b1;
    pc = 0; mc = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (i == 0) begin start = 1'b0; check("mag_first_cycle", mag_on, 1); end
      if (mag_on) mc++;
      if (timer_enable) pc++;
      if (state == 3'd3) break;
    end
    check("cook_reached_done", state, 3);
    check("pulse_count", pc, 2);
    check("mag_cycles", mc, 10);
    dc = 0;
    for (int i = 0; i < 40 && state == 3'd3; i++) begin dc++; cyc(1); end
    check("done_cycles", dc, ALARM_ON ? AT * TD : 1);

    // Door opened right after the first pulse, then resumed
    wait_state(0, 10, "idle_before_pause");
    load(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 20 && !timer_enable; i++) cyc(1);
    check("first_pulse_seen", timer_enable, 1);
    door_closed = 1'b0;
    cyc(1);
    check("door_pause_state", state, 2);
    check("door_pause_mag", mag_on, 0);
    cyc(3);
    door_closed = 1'b1; start = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      start = 1'b0;
      k++;
      if (timer_enable) break;
    end
    check("resume_to_pulse", k, TD);
    wait_state(3, 20, "resume_done");
    wait_state(0, 40, "resume_idle");

    // start and stop together while paused
    load(5);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_pause", state, 2);
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", state, 0);

    // Reset in the middle of cooking
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("cooking_before_reset", state, 1);
    clearn = 1'b0; start = 1'b1; stop = 1'b1;
    cyc(1);
    clearn = 1'b1; start = 1'b0; stop = 1'b0;
    check_reset_values("midreset");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      clear_key = ($urandom_range(0, 39) == 0);
      load_key  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
      clearn    = ($urandom_range(0, 499) != 0);
      if (load_key) kp_value = $urandom_range(0, 9);
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
